// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// One owner at a time, registered one-hot grant, locked ownership capped at HOLD_MAX cycles.
module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           lock,
    input  logic [N*WIDTH-1:0]     wdata,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);

    localparam int             OW       = $clog2(N);
    localparam logic [OW:0]    NW       = (OW+1)'(N);
    localparam logic [3:0]     HOLD_CNT = 4'(HOLD_MAX);

    localparam logic [0:0]     ST_IDLE  = 1'b0;
    localparam logic [0:0]     ST_OWN   = 1'b1;

    logic [0:0]        r_state;
    logic [N-1:0]      r_gnt;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_ptr;
    logic [3:0]        r_cnt;
    logic [WIDTH-1:0]  r_q;

    logic [OW:0]       w_sum [N];
    logic [OW-1:0]     w_idx [N];
    logic [WIDTH-1:0]  w_slot [N];
    logic [N-1:0]      w_win_oh;
    logic [OW-1:0]     w_winner;
    logic              w_any;
    logic [OW:0]       w_wp1;
    logic [OW-1:0]     w_ptr_next;
    logic              w_owner_req;
    logic              w_owner_lock;
    logic [WIDTH-1:0]  w_owner_data;
    logic              w_keep;

    // Candidate index for each priority slot: (ptr + gi) mod N, done without a divider.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            assign w_sum[gi]    = {1'b0, r_ptr} + (OW+1)'(gi);
            assign w_idx[gi]    = (w_sum[gi] >= NW) ? OW'(w_sum[gi] - NW) : OW'(w_sum[gi]);
            assign w_slot[gi]   = wdata[gi*WIDTH +: WIDTH];
            assign w_win_oh[gi] = (w_winner == OW'(gi));
        end
    endgenerate

    // Scan from lowest priority upwards so the slot nearest ptr overrides the rest.
    always_comb begin
        w_winner = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (req[w_idx[k]]) begin
                w_winner = w_idx[k];
            end
        end
    end

    assign w_any        = |req;
    assign w_wp1        = {1'b0, w_winner} + {{OW{1'b0}}, 1'b1};
    assign w_ptr_next   = (w_wp1 >= NW) ? '0 : w_wp1[OW-1:0];
    assign w_owner_req  = req[r_owner];
    assign w_owner_lock = lock[r_owner];
    assign w_owner_data = w_slot[r_owner];
    assign w_keep       = w_owner_req && w_owner_lock && (r_cnt < HOLD_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win_oh;
                        r_owner <= w_winner;
                        r_ptr   <= w_ptr_next;
                        r_cnt   <= 4'd1;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (w_owner_req) begin
                        r_q <= w_owner_data;
                    end
                    // Handover loads the next owner directly, so the grant never idles in between.
                    if (w_keep) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else if (w_any) begin
                        r_gnt   <= w_win_oh;
                        r_owner <= w_winner;
                        r_ptr   <= w_ptr_next;
                        r_cnt   <= 4'd1;
                    end else begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = (r_state == ST_OWN);
    assign q     = r_q;

endmodule
